e_mdu: RTL and testbench

- Multiply/divide unit for the E stage; sits beside the ALU and consumes the same forwarded operands (E_FW_Rdata1 → rs, E_FW_Rdata2 → rt).
- Executes mult/multu/div/divu with multi-cycle latency and owns the HI/LO registers.
- Handles mthi/mtlo writes and provides mfhi/mflo read data to the E-stage GRF write-data mux.
- Exports busy/start so the hazard controller can stall D-stage MD instructions.

---
 rtl/e_mdu_pkg.sv | 43 ++++
 rtl/e_mdu_md_calc.sv | 91 +++++++++
 rtl/e_mdu.sv | 154 +++++++++++++++
 tb/tb_e_mdu.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_pkg
// Purpose  : Shared definitions for the E-stage multiply/divide unit. The
//            E_controller decoder uses the same op codes.
// Contents : MD op codes, HI/LO read-select values, default latencies,
//            op-class helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package e_mdu_pkg;

    localparam int c_MD_OP_W = 3;

    // MD operation codes carried down the pipe from the decoder
    localparam logic [c_MD_OP_W-1:0] c_MD_NONE  = 3'd0;
    localparam logic [c_MD_OP_W-1:0] c_MD_MULT  = 3'd1;
    localparam logic [c_MD_OP_W-1:0] c_MD_MULTU = 3'd2;
    localparam logic [c_MD_OP_W-1:0] c_MD_DIV   = 3'd3;
    localparam logic [c_MD_OP_W-1:0] c_MD_DIVU  = 3'd4;
    localparam logic [c_MD_OP_W-1:0] c_MD_MTHI  = 3'd5;
    localparam logic [c_MD_OP_W-1:0] c_MD_MTLO  = 3'd6;

    // Read select for mfhi/mflo
    localparam logic c_RSEL_LO = 1'b0;
    localparam logic c_RSEL_HI = 1'b1;

    // Default latencies and counter width
    localparam int c_MULT_CYCLES_DEF = 5;
    localparam int c_DIV_CYCLES_DEF  = 10;
    localparam int c_CNT_W_DEF       = 4;

    // Ops that occupy the unit for several cycles
    function automatic logic md_is_calc(input logic [c_MD_OP_W-1:0] op);
        return (op == c_MD_MULT) || (op == c_MD_MULTU) ||
               (op == c_MD_DIV)  || (op == c_MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [c_MD_OP_W-1:0] op);
        return (op == c_MD_DIV) || (op == c_MD_DIVU);
    endfunction

endpackage : e_mdu_pkg
`default_nettype wire

// File: rtl/e_mdu_md_calc.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_md_calc
// Purpose  : Purely combinational result generator for mult/multu/div/divu.
// Ports    : op   - MD op code (non-arithmetic ops give zero results)
//            a, b - rs / rt operands
//            hi   - upper product word / remainder
//            lo   - lower product word / quotient
//            div0 - divide op with b == 0 (result must not be committed)
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu_md_calc
    import e_mdu_pkg::*;
(
    input  logic [c_MD_OP_W-1:0] op,
    input  logic [31:0]          a,
    input  logic [31:0]          b,
    output logic [31:0]          hi,
    output logic [31:0]          lo,
    output logic                 div0
);

    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic        [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_bs_safe;
    logic        [31:0] w_bu_safe;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic        [31:0] w_q_u;
    logic        [31:0] w_r_u;

    // Sign-extend to 64 bits so the truncated 64-bit product is exact
    assign w_a_sx   = {{32{a[31]}}, a};
    assign w_b_sx   = {{32{b[31]}}, b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Divisor is replaced by 1 for b==0 (result discarded anyway) and for
    // the INT_MIN / -1 overflow case, where dividing by 1 yields the
    // wrapped quotient INT_MIN with remainder 0.
    assign w_b_zero  = (b == 32'd0);
    assign w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_a_s     = a;
    assign w_bs_safe = (w_b_zero || w_div_ovf) ? 32'sd1 : b;
    assign w_bu_safe = w_b_zero ? 32'd1 : b;

    // SystemVerilog signed / and % truncate toward zero, remainder takes
    // the dividend's sign
    assign w_q_s = w_a_s / w_bs_safe;
    assign w_r_s = w_a_s % w_bs_safe;
    assign w_q_u = a / w_bu_safe;
    assign w_r_u = a % w_bu_safe;

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = 1'b0;
        case (op)
            c_MD_MULT: begin
                hi = w_prod_s[63:32];
                lo = w_prod_s[31:0];
            end
            c_MD_MULTU: begin
                hi = w_prod_u[63:32];
                lo = w_prod_u[31:0];
            end
            c_MD_DIV: begin
                hi   = w_r_s;
                lo   = w_q_s;
                div0 = w_b_zero;
            end
            c_MD_DIVU: begin
                hi   = w_r_u;
                lo   = w_q_u;
                div0 = w_b_zero;
            end
            default: begin
                hi   = 32'd0;
                lo   = 32'd0;
                div0 = 1'b0;
            end
        endcase
    end

endmodule : e_mdu_md_calc
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Purpose  : E-stage multiply/divide unit. Owns HI/LO, runs mult/div with a
//            fixed multi-cycle busy window, handles mthi/mtlo and supplies
//            mfhi/mflo read data.
// Ports    : clk        - system clock
//            reset      - synchronous active-low reset
//            E_valid    - E-stage instruction is real; gates all writes
//            E_md_op    - MD op code (e_mdu_pkg)
//            E_md_rsel  - read select, 0 = LO, 1 = HI
//            E_A, E_B   - forwarded rs / rt values
//            E_md_start - arithmetic op accepted this cycle (combinational)
//            E_busy     - operation in flight (registered)
//            E_md_out   - committed HI or LO per E_md_rsel
//            HI, LO     - committed HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF,
    parameter int CNT_W       = c_CNT_W_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 E_valid,
    input  logic [c_MD_OP_W-1:0] E_md_op,
    input  logic                 E_md_rsel,
    input  logic [31:0]          E_A,
    input  logic [31:0]          E_B,
    output logic                 E_md_start,
    output logic                 E_busy,
    output logic [31:0]          E_md_out,
    output logic [31:0]          HI,
    output logic [31:0]          LO
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    // Counter is loaded with N-1 and the commit happens on the edge where it
    // is already 0, giving exactly N busy cycles.
    localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_div0;

    logic             w_busy;
    logic             w_done;
    logic             w_start;
    logic             w_mt_ok;
    logic [31:0]      w_calc_hi;
    logic [31:0]      w_calc_lo;
    logic             w_calc_div0;

    e_mdu_md_calc u_md_calc (
        .op   (E_md_op),
        .a    (E_A),
        .b    (E_B),
        .hi   (w_calc_hi),
        .lo   (w_calc_lo),
        .div0 (w_calc_div0)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_start)        w_state_nxt = c_S_RUN;
            c_S_RUN:  if (r_cnt == '0)    w_state_nxt = c_S_IDLE;
            default:                      w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = (r_state == c_S_RUN);
        w_done = (r_state == c_S_RUN) && (r_cnt == '0);
    end

    // Starts and moves are only honoured while idle; in legal flow the
    // hazard unit never presents them while busy.
    assign w_start = E_valid && md_is_calc(E_md_op) && !w_busy;
    assign w_mt_ok = E_valid && !w_busy;

    // ------------------------------------------------------------------
    // Datapath: counter, pending result, HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_div0 <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            if (w_start) begin
                r_cnt       <= md_is_div(E_md_op) ? c_DIV_LOAD : c_MULT_LOAD;
                r_pend_hi   <= w_calc_hi;
                r_pend_lo   <= w_calc_lo;
                r_pend_div0 <= w_calc_div0;
            end else if (w_busy && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // Divide by zero still takes the full busy window but leaves
            // HI/LO untouched.
            if (w_done && !r_pend_div0) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end

            if (w_mt_ok && (E_md_op == c_MD_MTHI)) begin
                r_hi <= E_A;
            end
            if (w_mt_ok && (E_md_op == c_MD_MTLO)) begin
                r_lo <= E_A;
            end
        end
    end

    assign E_md_start = w_start;
    assign E_busy     = w_busy;
    assign E_md_out   = (E_md_rsel == c_RSEL_HI) ? r_hi : r_lo;
    assign HI         = r_hi;
    assign LO         = r_lo;

endmodule : e_mdu
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Purpose  : Self-checking bench for e_mdu. Expected HI/LO and busy-window
//            length are queued when an op is issued and compared when the
//            busy window closes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        E_valid   = 1'b0;
    logic [2:0]  E_md_op   = c_MD_NONE;
    logic        E_md_rsel = 1'b0;
    logic [31:0] E_A       = 32'd0;
    logic [31:0] E_B       = 32'd0;
    logic        E_md_start;
    logic        E_busy;
    logic [31:0] E_md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    e_mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .E_valid    (E_valid),
        .E_md_op    (E_md_op),
        .E_md_rsel  (E_md_rsel),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_md_start (E_md_start),
        .E_busy     (E_busy),
        .E_md_out   (E_md_out),
        .HI         (HI),
        .LO         (LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model for arithmetic ops, based on the architectural HI/LO
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t    e;
        longint  sa;
        longint  sbv;
        logic [63:0] p;
        int      ia;
        int      ib;
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.busy = (op == c_MD_DIV || op == c_MD_DIVU) ? 10 : 5;
        case (op)
            c_MD_MULT: begin
                ia = a; ib = b;
                sa = ia; sbv = ib;
                p  = sa * sbv;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            c_MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            c_MD_DIV: begin
                if (b != 32'd0) begin
                    ia = a; ib = b;
                    e.lo = ia / ib;
                    e.hi = ia % ib;
                end
            end
            c_MD_DIVU: begin
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: measure busy window, compare on its falling edge
    int   busy_len  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (E_busy === 1'b1) begin
            busy_len++;
        end else if (prev_busy) begin
            chk("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("res_hi", HI, e.hi);
                chk("res_lo", LO, e.lo);
                chk("busy_len", 64'(busy_len), 64'(e.busy));
            end
            busy_len = 0;
        end
        prev_busy = (E_busy === 1'b1);
    end

    // Issue an arithmetic op for one cycle and queue its expected result
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        @(posedge clk); #1;
        E_valid = 1'b1; E_md_op = op; E_A = a; E_B = b;
        #1;
        chk("md_start", E_md_start, 1'b1);
        @(posedge clk); #1;
        E_valid = 1'b0; E_md_op = c_MD_NONE;
    endtask

    // Drive mthi/mtlo now (caller is already past an edge)
    task automatic mt_now(input logic [2:0] op, input logic [31:0] a, input logic valid);
        E_valid = valid; E_md_op = op; E_A = a;
        if (valid && op == c_MD_MTHI) m_hi = a;
        if (valid && op == c_MD_MTLO) m_lo = a;
        @(posedge clk); #1;
        E_valid = 1'b0; E_md_op = c_MD_NONE;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a, input logic valid);
        @(posedge clk); #1;
        mt_now(op, a, valid);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (E_busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_idle_timeout"}, 64'(k < 100), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", E_busy, 1'b0);
        chk("rst_out", E_md_out, 32'd0);

        // Signed and unsigned multiply of the same operands
        issue(c_MD_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle("mult");
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);
        issue(c_MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu");
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        // Signed divide truncating toward zero, then unsigned
        issue(c_MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div");
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        issue(c_MD_DIVU, 32'd7, 32'd2);
        wait_idle("divu");
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        // Moves, then divide by zero leaves HI/LO alone
        mt(c_MD_MTHI, 32'h11, 1'b1);
        chk("mthi", HI, 32'h11);
        mt(c_MD_MTLO, 32'h22, 1'b1);
        chk("mtlo", LO, 32'h22);
        issue(c_MD_DIV, 32'd100, 32'd0);
        wait_idle("div0");
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h22);
        E_md_rsel = c_RSEL_HI; #1;
        chk("out_hi", E_md_out, 32'h11);
        E_md_rsel = c_RSEL_LO; #1;
        chk("out_lo", E_md_out, 32'h22);

        // MTHI and a second MULT while busy are ignored
        issue(c_MD_MULT, 32'd3, 32'd4);
        @(posedge clk); #1;
        E_valid = 1'b1; E_md_op = c_MD_MTHI; E_A = 32'h55;
        @(posedge clk); #1;
        E_md_op = c_MD_MULT; E_A = 32'd9; E_B = 32'd9;
        #1;
        chk("start_blocked", E_md_start, 1'b0);
        @(posedge clk); #1;
        E_valid = 1'b0; E_md_op = c_MD_NONE;
        wait_idle("busy_ign");
        repeat (8) @(posedge clk);
        #1;
        chk("ign_busy", E_busy, 1'b0);
        chk("ign_hi", HI, 32'd0);
        chk("ign_lo", LO, 32'd12);
        mt(c_MD_MTLO, 32'h99, 1'b0);
        chk("inval_mtlo", LO, 32'd12);

        // Randomised arithmetic against the model
        for (int i = 0; i < 8; i++) begin
            op = 3'(int'(c_MD_MULT) + $urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ((op == c_MD_DIV || op == c_MD_DIVU) && $urandom_range(0, 1) == 1)
                b = (op == c_MD_DIV && $urandom_range(0, 1) == 1) ?
                    -32'($urandom_range(1, 100)) : 32'($urandom_range(1, 100));
            if (op == c_MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                b = 32'd1;
            issue(op, a, b);
            wait_idle("rand");
        end
        mt(c_MD_MTHI, 32'hA5A5_0001, 1'b1);
        mt(c_MD_MTLO, 32'h5A5A_0002, 1'b1);

        // Reset during busy cycle 3 aborts the op
        sb.push_back('{hi: 32'd0, lo: 32'd0, busy: 3});
        @(posedge clk); #1;
        E_valid = 1'b1; E_md_op = c_MD_MULT; E_A = 32'd5; E_B = 32'd5;
        @(posedge clk); #1;
        E_valid = 1'b0; E_md_op = c_MD_NONE;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("abort_busy", E_busy, 1'b0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_late_busy", E_busy, 1'b0);
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);

        // MTLO on the first idle cycle after a MULT completes
        issue(c_MD_MULT, 32'd2, 32'd3);
        wait_idle("b2b");
        mt_now(c_MD_MTLO, 32'h7, 1'b1);
        chk("b2b_lo", LO, 32'h7);
        chk("b2b_hi", HI, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_e_mdu
`default_nettype wire
